// File: rtl/cw305_batch_trigger_seq.sv
// Batch sequencer between the AES register block and the crypto core.
// One start runs a batch of back-to-back encryptions with fixed or
// incrementing plaintext, per-block trigger windows and busy-cycle timing.
module cw305_batch_trigger_seq #(
  parameter int pPT_WIDTH  = 128,
  parameter int pCNT_WIDTH = 16,
  parameter int pDLY_WIDTH = 16,
  parameter int pTRIG_CH   = 2,
  parameter int pCYC_WIDTH = 32,
  parameter int pGAP       = 4,
  parameter int pBUSY_TMO  = 8
) (
  input  logic                           crypto_clk,
  input  logic                           resetn,
  input  logic                           I_start,
  input  logic                           I_abort,
  input  logic [pCNT_WIDTH-1:0]          I_batch_len,
  input  logic [pPT_WIDTH-1:0]           I_pt_seed,
  input  logic                           I_pt_mode,
  input  logic [pTRIG_CH-1:0]            I_trig_en,
  input  logic [pTRIG_CH*pDLY_WIDTH-1:0] I_trig_dly,
  input  logic [pTRIG_CH*pDLY_WIDTH-1:0] I_trig_width,
  input  logic                           I_busy,
  output logic                           O_load,
  output logic [pPT_WIDTH-1:0]           O_text,
  output logic [pTRIG_CH-1:0]            O_trig,
  output logic                           O_busy,
  output logic                           O_done,
  output logic                           O_err,
  output logic [pCNT_WIDTH-1:0]          O_blk_cnt,
  output logic [pCYC_WIDTH-1:0]          O_cyc_cnt
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  // Trigger time counter is one bit wider than the delay/width fields so
  // that dly+width never wraps.
  localparam int TW  = pDLY_WIDTH + 1;
  localparam int WCW = $clog2(pBUSY_TMO + 1) + 1;
  localparam int GCW = $clog2(pGAP + 1) + 1;

  logic [2:0]                    state, state_nx;
  logic [pCNT_WIDTH-1:0]         len_q, blk_nx;
  logic [pPT_WIDTH-1:0]          pt;
  logic                          mode_q;
  logic [pTRIG_CH-1:0]           en_q;
  logic [pTRIG_CH*pDLY_WIDTH-1:0] dly_q, wid_q;
  logic [WCW-1:0]                wcnt;
  logic [GCW-1:0]                gcnt;
  logic [pCYC_WIDTH-1:0]         cyc;
  logic [TW-1:0]                 tcnt, t_nx;
  logic [pTRIG_CH-1:0]           trig_nx;
  logic                          accept, zero_start, active_nx;

  function automatic logic [pCYC_WIDTH-1:0] cyc_sat_inc(input logic [pCYC_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [TW-1:0] t_sat_inc(input logic [TW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign accept     = (state == S_IDLE) && I_start && !I_abort;
  assign zero_start = accept && (I_batch_len == '0);
  assign blk_nx     = O_blk_cnt + 1'b1;

  assign O_load = (state == S_LOAD);
  assign O_busy = (state != S_IDLE);
  assign O_text = pt;

  // Next-state decode; abort overrides every state.
  always_comb begin
    state_nx = state;
    if (I_abort) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (I_start && (I_batch_len != '0)) state_nx = S_LOAD;
        S_LOAD: state_nx = S_WAIT;
        S_WAIT: begin
          if (I_busy) state_nx = S_RUN;
          else if (wcnt == WCW'(pBUSY_TMO)) state_nx = S_IDLE;
        end
        S_RUN: if (!I_busy) state_nx = (blk_nx == len_q) ? S_DONE : S_GAP;
        S_GAP: if (gcnt == GCW'(pGAP - 1)) state_nx = S_LOAD;
        S_DONE: state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Trigger windows evaluated on next-cycle time so O_trig can be registered.
  always_comb begin
    t_nx      = (state == S_LOAD) ? '0 : t_sat_inc(tcnt);
    active_nx = (state_nx == S_WAIT) || (state_nx == S_RUN) ||
                (state_nx == S_GAP)  || (state_nx == S_DONE);
    trig_nx   = '0;
    for (int c = 0; c < pTRIG_CH; c++) begin
      trig_nx[c] = active_nx && en_q[c] &&
                   (t_nx >= {1'b0, dly_q[c*pDLY_WIDTH +: pDLY_WIDTH]}) &&
                   (t_nx <  ({1'b0, dly_q[c*pDLY_WIDTH +: pDLY_WIDTH]} +
                             {1'b0, wid_q[c*pDLY_WIDTH +: pDLY_WIDTH]}));
    end
  end

  // Sequencer state, latched batch config, counters and registered outputs.
  always_ff @(posedge crypto_clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      len_q     <= '0;
      pt        <= '0;
      mode_q    <= 1'b0;
      en_q      <= '0;
      dly_q     <= '0;
      wid_q     <= '0;
      wcnt      <= '0;
      gcnt      <= '0;
      cyc       <= '0;
      tcnt      <= '0;
      O_trig    <= '0;
      O_done    <= 1'b0;
      O_err     <= 1'b0;
      O_blk_cnt <= '0;
      O_cyc_cnt <= '0;
    end else begin
      state  <= state_nx;
      tcnt   <= t_nx;
      O_trig <= trig_nx;
      O_done <= (state_nx == S_DONE) || zero_start;
      if (accept) begin
        len_q     <= I_batch_len;
        pt        <= I_pt_seed;
        mode_q    <= I_pt_mode;
        en_q      <= I_trig_en;
        dly_q     <= I_trig_dly;
        wid_q     <= I_trig_width;
        O_blk_cnt <= '0;
        O_err     <= 1'b0;
      end
      if (!I_abort) begin
        case (state)
          S_LOAD: wcnt <= WCW'(1);
          S_WAIT: begin
            if (I_busy) cyc <= pCYC_WIDTH'(1);
            else if (wcnt == WCW'(pBUSY_TMO)) O_err <= 1'b1;
            else wcnt <= wcnt + 1'b1;
          end
          S_RUN: begin
            if (I_busy) begin
              cyc <= cyc_sat_inc(cyc);
            end else begin
              O_cyc_cnt <= cyc;
              O_blk_cnt <= blk_nx;
              gcnt      <= '0;
            end
          end
          S_GAP: begin
            gcnt <= gcnt + 1'b1;
            if ((gcnt == GCW'(pGAP - 1)) && mode_q) pt <= pt + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cw305_batch_trigger_seq.sv
// Directed bench for cw305_batch_trigger_seq: a small core model answers
// each load with a busy pulse, and a scoreboard queue holds expected texts.
module tb_cw305_batch_trigger_seq;
  localparam int PTW = 128, CW = 16, DW = 16, TC = 2, CYW = 32, GAP = 4, TMO = 8;

  logic              crypto_clk = 1'b0;
  logic              resetn = 1'b0;
  logic              I_start = 1'b0, I_abort = 1'b0, I_pt_mode = 1'b0, I_busy = 1'b0;
  logic [CW-1:0]     I_batch_len = '0;
  logic [PTW-1:0]    I_pt_seed = '0;
  logic [TC-1:0]     I_trig_en = '0;
  logic [TC*DW-1:0]  I_trig_dly = '0, I_trig_width = '0;
  logic              O_load, O_busy, O_done, O_err;
  logic [PTW-1:0]    O_text;
  logic [TC-1:0]     O_trig;
  logic [CW-1:0]     O_blk_cnt;
  logic [CYW-1:0]    O_cyc_cnt;

  cw305_batch_trigger_seq #(
    .pPT_WIDTH(PTW), .pCNT_WIDTH(CW), .pDLY_WIDTH(DW), .pTRIG_CH(TC),
    .pCYC_WIDTH(CYW), .pGAP(GAP), .pBUSY_TMO(TMO)
  ) dut (
    .crypto_clk(crypto_clk), .resetn(resetn), .I_start(I_start), .I_abort(I_abort),
    .I_batch_len(I_batch_len), .I_pt_seed(I_pt_seed), .I_pt_mode(I_pt_mode),
    .I_trig_en(I_trig_en), .I_trig_dly(I_trig_dly), .I_trig_width(I_trig_width),
    .I_busy(I_busy), .O_load(O_load), .O_text(O_text), .O_trig(O_trig),
    .O_busy(O_busy), .O_done(O_done), .O_err(O_err), .O_blk_cnt(O_blk_cnt),
    .O_cyc_cnt(O_cyc_cnt)
  );

  always #5 crypto_clk = ~crypto_clk;

  int compared = 0, mismatched = 0;
  logic [PTW-1:0] exp_q[$];
  int loads = 0, dones = 0, cyc_no = 0, load_cyc = 0;
  int core_cycles = 10, busy_rem = 0;
  bit core_on = 1'b1, busy_pend = 1'b0;
  logic [TC-1:0] cfg_en = '0;
  int cfg_dly[TC], cfg_w[TC], trig_hi[TC];
  int tb_t = 0;
  bit tb_act = 1'b0;

  task automatic chk(input string tag, input logic [PTW-1:0] obs, input logic [PTW-1:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge crypto_clk) cyc_no++;

  // Core model: busy rises the cycle after a load and stays high core_cycles samples.
  always @(negedge crypto_clk) begin
    if (busy_rem > 0) begin
      busy_rem--;
      if (busy_rem == 0) I_busy = 1'b0;
    end
    if (busy_pend) begin
      busy_pend = 1'b0;
      I_busy = 1'b1;
      busy_rem = core_cycles;
    end
    if (O_load && core_on) busy_pend = 1'b1;
  end

  // Monitor: scoreboard pops on load, done counting, per-cycle trigger model.
  always @(negedge crypto_clk) begin
    logic expb;
    if (O_load) begin
      loads++;
      load_cyc = cyc_no;
      chk("q_has_entry", PTW'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("text", O_text, exp_q.pop_front());
    end
    if (O_done) dones++;
    for (int c = 0; c < TC; c++) begin
      expb = 1'b0;
      if (!O_load && O_busy && tb_act)
        expb = cfg_en[c] && (tb_t >= cfg_dly[c]) && (tb_t < cfg_dly[c] + cfg_w[c]);
      chk($sformatf("trig%0d_t%0d", c, tb_t), PTW'(O_trig[c]), PTW'(expb));
      if (O_trig[c]) trig_hi[c]++;
    end
    if (O_load) begin
      tb_t = 0;
      tb_act = 1'b1;
    end else if (!O_busy) tb_act = 1'b0;
    else if (tb_act) tb_t++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge crypto_clk);
    #1;
  endtask

  task automatic start(input int len, input logic [PTW-1:0] seed, input bit mode,
                       input logic [TC-1:0] en, input int d0, input int w0,
                       input int d1, input int w1);
    logic [PTW-1:0] p;
    I_batch_len = CW'(len);
    I_pt_seed = seed;
    I_pt_mode = mode;
    I_trig_en = en;
    I_trig_dly = {DW'(d1), DW'(d0)};
    I_trig_width = {DW'(w1), DW'(w0)};
    cfg_en = en; cfg_dly[0] = d0; cfg_w[0] = w0; cfg_dly[1] = d1; cfg_w[1] = w1;
    p = seed;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(p);
      if (mode) p = p + 1'b1;
    end
    I_start = 1'b1;
    tick(1);
    I_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (O_busy && n < 400) begin
      tick(1);
      n++;
    end
    chk({tag, "_idle_wait"}, PTW'(O_busy), 0);
  endtask

  task automatic wait_loads(input int target);
    int n = 0;
    while (loads < target && n < 200) begin
      tick(1);
      n++;
    end
    chk("load_wait", PTW'(loads >= target), 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_load"}, PTW'(O_load), 0);
    chk({tag, "_text"}, O_text, 0);
    chk({tag, "_trig"}, PTW'(O_trig), 0);
    chk({tag, "_busy"}, PTW'(O_busy), 0);
    chk({tag, "_done"}, PTW'(O_done), 0);
    chk({tag, "_err"}, PTW'(O_err), 0);
    chk({tag, "_blk"}, PTW'(O_blk_cnt), 0);
    chk({tag, "_cyc"}, PTW'(O_cyc_cnt), 0);
  endtask

  initial begin
    int l0, d0, n;
    for (int c = 0; c < TC; c++) begin
      cfg_dly[c] = 0; cfg_w[c] = 0; trig_hi[c] = 0;
    end
    tick(2);
    chk_all_zero("reset");
    resetn = 1'b1;
    tick(2);

    // Incrementing plaintext batch of three.
    l0 = loads; d0 = dones;
    start(3, '0, 1'b1, 2'b00, 0, 0, 0, 0);
    wait_idle("inc3");
    chk("inc3_loads", PTW'(loads - l0), 3);
    chk("inc3_dones", PTW'(dones - d0), 1);
    chk("inc3_cyc", PTW'(O_cyc_cnt), 10);
    chk("inc3_blk", PTW'(O_blk_cnt), 3);
    chk("inc3_q_empty", PTW'(exp_q.size()), 0);
    tick(2);

    // Fixed plaintext with one trigger channel window t=2..4.
    l0 = loads;
    trig_hi[0] = 0; trig_hi[1] = 0;
    start(2, 128'h1234_5678, 1'b0, 2'b01, 2, 3, 0, 5);
    wait_idle("trig");
    tick(1);
    chk("trig0_high_cycles", PTW'(trig_hi[0]), 6);
    chk("trig1_high_cycles", PTW'(trig_hi[1]), 0);
    chk("trig_loads", PTW'(loads - l0), 2);
    chk("trig_blk", PTW'(O_blk_cnt), 2);

    // Zero-length batch.
    l0 = loads; d0 = dones;
    start(0, 128'h99, 1'b0, 2'b00, 0, 0, 0, 0);
    chk("len0_done_next", PTW'(O_done), 1);
    chk("len0_busy", PTW'(O_busy), 0);
    tick(5);
    chk("len0_no_load", PTW'(loads - l0), 0);
    chk("len0_one_done", PTW'(dones - d0), 1);

    // Busy timeout, then the next start clears the error.
    core_on = 1'b0;
    d0 = dones;
    start(1, 128'h5, 1'b0, 2'b00, 0, 0, 0, 0);
    n = 0;
    while (!O_err && n < 50) begin
      tick(1);
      n++;
    end
    chk("tmo_err", PTW'(O_err), 1);
    chk("tmo_latency", PTW'(cyc_no - load_cyc), TMO + 1);
    chk("tmo_idle", PTW'(O_busy), 0);
    tick(3);
    chk("tmo_no_done", PTW'(dones - d0), 0);
    core_on = 1'b1;
    start(1, 128'h7, 1'b0, 2'b00, 0, 0, 0, 0);
    chk("tmo_err_cleared", PTW'(O_err), 0);
    wait_idle("tmo_retry");
    chk("tmo_retry_done", PTW'(dones - d0), 1);
    tick(2);

    // Abort in RUN of block 2 of 5, with a simultaneous start.
    l0 = loads; d0 = dones;
    start(5, 128'd100, 1'b1, 2'b11, 0, 30, 0, 30);
    wait_loads(l0 + 2);
    tick(3);
    chk("abort_pre_trig", PTW'(O_trig), 3);
    I_abort = 1'b1;
    I_start = 1'b1;
    I_batch_len = CW'(9);
    tick(1);
    I_abort = 1'b0;
    I_start = 1'b0;
    chk("abort_busy", PTW'(O_busy), 0);
    chk("abort_trig", PTW'(O_trig), 0);
    chk("abort_load", PTW'(O_load), 0);
    chk("abort_blk", PTW'(O_blk_cnt), 1);
    tick(20);
    chk("abort_no_done", PTW'(dones - d0), 0);
    chk("abort_start_dropped", PTW'(loads - (l0 + 2)), 0);
    chk("abort_still_idle", PTW'(O_busy), 0);
    exp_q.delete();

    // Plaintext wrap from all-ones.
    l0 = loads;
    start(2, '1, 1'b1, 2'b00, 0, 0, 0, 0);
    wait_idle("wrap");
    chk("wrap_q_empty", PTW'(exp_q.size()), 0);
    chk("wrap_last_text", O_text, 0);
    chk("wrap_loads", PTW'(loads - l0), 2);

    // Asynchronous reset in the middle of RUN.
    l0 = loads;
    start(3, 128'd55, 1'b1, 2'b01, 0, 40, 0, 0);
    wait_loads(l0 + 1);
    tick(3);
    chk("prereset_busy", PTW'(O_busy), 1);
    #2 resetn = 1'b0;
    #1 chk_all_zero("async_rst");
    @(posedge crypto_clk);
    #1 resetn = 1'b1;
    exp_q.delete();
    tick(20);
    chk("post_rst_idle", PTW'(O_busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
